// File: rtl/flag_display_scheduler.sv
// Time-multiplexes latched C/N/Z flags onto a one-hot decoder select, one glyph at a time.
// Define FLAG_SCHED_GAP_EN to insert GAP_CYCLES blank cycles between glyphs.
module flag_display_scheduler #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flags_valid,
    input  logic [2:0] flags_C_N_Z,
    output logic [2:0] sel_C_N_Z,
    output logic       busy
);

`ifdef FLAG_SCHED_GAP_EN
    localparam int MAX_C = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
    typedef enum logic [1:0] {IDLE, STATIC, SHOW, GAP} state_t;
`else
    // GAP_CYCLES has no effect on sizing when blanking is compiled out.
    localparam int MAX_C = HOLD_CYCLES + 0 * GAP_CYCLES;
    typedef enum logic [1:0] {IDLE, STATIC, SHOW} state_t;
`endif
    localparam int CW = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    state_t          state_q, state_d;
    logic [2:0]      set_q, set_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      sel_q, sel_d;
    logic            busy_q, busy_d;

    function automatic logic [1:0] lowest_idx(input logic [2:0] s);
        if (s[0])      return 2'd0;
        else if (s[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    // Next set bit in ascending order with wrap-around.
    function automatic logic [1:0] next_idx(input logic [2:0] s, input logic [1:0] i);
        logic [1:0] r;
        case (i)
            2'd0:    r = s[1] ? 2'd1 : (s[2] ? 2'd2 : 2'd0);
            2'd1:    r = s[2] ? 2'd2 : (s[0] ? 2'd0 : 2'd1);
            default: r = s[0] ? 2'd0 : (s[1] ? 2'd1 : 2'd2);
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (flags_valid) begin
            set_d = flags_C_N_Z;
            cnt_d = '0;
            idx_d = lowest_idx(flags_C_N_Z);
            case ($countones(flags_C_N_Z))
                0:       state_d = IDLE;
                1:       state_d = STATIC;
                default: state_d = SHOW;
            endcase
        end else begin
            case (state_q)
                SHOW: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        cnt_d = '0;
`ifdef FLAG_SCHED_GAP_EN
                        state_d = GAP;
`else
                        idx_d = next_idx(set_q, idx_q);
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef FLAG_SCHED_GAP_EN
                GAP: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        cnt_d   = '0;
                        idx_d   = next_idx(set_q, idx_q);
                        state_d = SHOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                default: cnt_d = '0;
            endcase
        end

        // Outputs are computed from the next state so they can be registered.
        sel_d  = 3'b000;
        busy_d = 1'b0;
        case (state_d)
            STATIC: sel_d = set_d;
            SHOW: begin
                sel_d  = 3'b001 << idx_d;
                busy_d = 1'b1;
            end
`ifdef FLAG_SCHED_GAP_EN
            GAP: busy_d = 1'b1;
`endif
            default: sel_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            set_q   <= 3'b000;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            sel_q   <= 3'b000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign sel_C_N_Z = sel_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_flag_display_scheduler.sv
// Scoreboard bench for flag_display_scheduler: directed scenarios then random strobes,
// compared cycle-by-cycle against a timeline model of the display.
module tb_flag_display_scheduler;
    localparam int HOLD = 4;
    localparam int GAPC = 2;
`ifdef FLAG_SCHED_GAP_EN
    localparam int SLOT = HOLD + GAPC;
`else
    localparam int SLOT = HOLD;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flags_valid = 1'b0;
    logic [2:0] flags_C_N_Z = 3'b000;
    logic [2:0] sel_C_N_Z;
    logic       busy;

    flag_display_scheduler #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flags_valid (flags_valid),
        .flags_C_N_Z (flags_C_N_Z),
        .sel_C_N_Z   (sel_C_N_Z),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];
    string      tag_q[$];
    string      cur_tag = "init";

    // Model: what is shown is a pure function of the latched set and the cycles since load.
    logic [2:0] m_set = 3'b000;
    int         m_t = 0;

    function automatic logic [3:0] model_out(input logic [2:0] s, input int t);
        int bits[$];
        int n, pos, g;
        logic [2:0] one;
        n = $countones(s);
        if (n == 0) return 4'b0000;
        if (n == 1) return {s, 1'b0};
        for (int i = 0; i < 3; i++) if (s[i]) bits.push_back(i);
        pos = t % (SLOT * n);
        g   = pos / SLOT;
        one = 3'b001 << bits[g];
        if ((pos % SLOT) < HOLD) return {one, 1'b1};
        return 4'b0001;
    endfunction

    task automatic step(input logic rst_b, input logic v, input logic [2:0] f);
        rst_n       = rst_b;
        flags_valid = v;
        flags_C_N_Z = f;
        if (!rst_b) begin
            m_set = 3'b000;
            m_t   = 0;
        end else if (v) begin
            m_set = f;
            m_t   = 0;
        end else begin
            m_t++;
        end
        exp_q.push_back(model_out(m_set, m_t));
        tag_q.push_back(cur_tag);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'b000);
    endtask

    // Monitor: the DUT presents a new sel/busy after every edge.
    initial begin
        logic [3:0] e;
        string      tg;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                tg = tag_q.pop_front();
                n_vec++;
                if ({sel_C_N_Z, busy} !== e) begin
                    n_bad++;
                    $display("FAIL %s @%0t: sel=%b busy=%b, required sel=%b busy=%b",
                             tg, $time, sel_C_N_Z, busy, e[3:1], e[0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        cur_tag = "reset";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b111);
        cur_tag = "post_reset";
        idle(4);

        cur_tag = "single_N";
        step(1'b1, 1'b1, 3'b010);
        idle(22);

        cur_tag = "rot_CZ";
        step(1'b1, 1'b1, 3'b101);
        idle(3 * SLOT * 2 + 2);

        cur_tag = "rot_all";
        step(1'b1, 1'b1, 3'b111);
        idle(SLOT * 3 + 4);

        cur_tag = "reload_tc";
        step(1'b1, 1'b1, 3'b111);
        idle(3);
        step(1'b1, 1'b1, 3'b110);
        idle(SLOT * 2 + 3);

        cur_tag = "same_reload";
        step(1'b1, 1'b1, 3'b011);
        idle(5);
        step(1'b1, 1'b1, 3'b011);
        idle(6);

        cur_tag = "clear";
        step(1'b1, 1'b1, 3'b111);
        idle(5);
        step(1'b1, 1'b1, 3'b000);
        idle(4);

        cur_tag = "mid_reset";
        step(1'b1, 1'b1, 3'b101);
        idle(6);
        step(1'b0, 1'b0, 3'b000);
        idle(5);

        cur_tag = "random";
        for (int i = 0; i < 1500; i++) begin
            logic r, v;
            r = ($urandom_range(0, 99) != 0);
            v = ($urandom_range(0, 14) == 0);
            step(r, v, 3'($urandom_range(0, 7)));
        end

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
